// File: rtl/la_zip_decode_router_if.sv
// Decoder-to-slave routing bus.
//  Upstream (decoder side): i_valid, o_stall, i_decode, i_addr, i_data, o_ack, o_err.
//  Downstream (slave side): o_svalid, i_sstall, o_saddr, o_sdata, i_sack.
//  modport master : the router itself (drives o_*, samples i_*).
//  modport slave  : the environment around the router (decoder + slaves).
interface la_zip_decode_router_if #(
  parameter int NS = 8,
  parameter int AW = 32,
  parameter int DW = 38
);
  logic          i_valid;
  logic          o_stall;
  logic [NS:0]   i_decode;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic [NS-1:0] o_svalid;
  logic [NS-1:0] i_sstall;
  logic [AW-1:0] o_saddr;
  logic [DW-1:0] o_sdata;
  logic [NS-1:0] i_sack;
  logic          o_ack;
  logic          o_err;

  modport master (
    input  i_valid, i_decode, i_addr, i_data, i_sstall, i_sack,
    output o_stall, o_svalid, o_saddr, o_sdata, o_ack, o_err
  );

  modport slave (
    output i_valid, i_decode, i_addr, i_data, i_sstall, i_sack,
    input  o_stall, o_svalid, o_saddr, o_sdata, o_ack, o_err
  );
endinterface

// File: rtl/la_zip_decode_router.sv
// Routes one-hot decoded requests to a single selected slave.
//  i_clk   : clock
//  i_reset : asynchronous active-high reset
//  bus     : routing bus (master modport), see la_zip_decode_router_if
// Requests are registered (1 cycle latency). An outstanding counter blocks a
// change of target slave until every in-flight request has been acked.
// A "no slave" decode (top bit) is answered locally with a one-cycle o_err.
module la_zip_decode_router #(
  parameter int NS       = 8,
  parameter int AW       = 32,
  parameter int DW       = 38,
  parameter int LGMAXOUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  la_zip_decode_router_if.master bus
);
  localparam logic [LGMAXOUT-1:0] CNT_MAX = '1;
  localparam logic [LGMAXOUT-1:0] CNT_ONE = LGMAXOUT'(1);

  logic [NS-1:0]       svalid_q, svalid_d;
  logic [AW-1:0]       saddr_q,  saddr_d;
  logic [DW-1:0]       sdata_q,  sdata_d;
  logic [NS:0]         sel_q,    sel_d;
  logic [LGMAXOUT-1:0] count_q,  count_d;
  logic                err_pend_q, err_pend_d;
  logic                ack_q,    ack_d;
  logic                err_q,    err_d;

  logic busy, cur_stall, stall, accept, acc_slv, acc_err, ack_hit;

  always_comb begin
    busy      = |svalid_q;
    cur_stall = |(svalid_q & bus.i_sstall);
    // Target switch only once the pipe to the previous slave has fully drained.
    stall     = (busy && cur_stall) || (count_q == CNT_MAX) || err_pend_q
                || ((count_q != '0) && (bus.i_decode != sel_q));
    accept    = bus.i_valid && !stall && (bus.i_decode != '0);
    acc_slv   = accept && !bus.i_decode[NS];
    acc_err   = accept &&  bus.i_decode[NS];
    // Only acks from the selected slave count, and never below zero.
    ack_hit   = (|(bus.i_sack & sel_q[NS-1:0])) && (count_q != '0);

    svalid_d   = svalid_q;
    saddr_d    = saddr_q;
    sdata_d    = sdata_q;
    sel_d      = sel_q;
    count_d    = count_q;
    err_pend_d = 1'b0;
    ack_d      = ack_hit;
    err_d      = err_pend_q;

    if (acc_slv) begin
      svalid_d = bus.i_decode[NS-1:0];
      saddr_d  = bus.i_addr;
      sdata_d  = bus.i_data;
      sel_d    = bus.i_decode;
    end else if (busy && !cur_stall) begin
      svalid_d = '0;
    end

    if (acc_err) begin
      err_pend_d = 1'b1;
      sel_d      = bus.i_decode;
    end

    case ({acc_slv, ack_hit})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      svalid_q   <= '0;
      saddr_q    <= '0;
      sdata_q    <= '0;
      sel_q      <= '0;
      count_q    <= '0;
      err_pend_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      svalid_q   <= svalid_d;
      saddr_q    <= saddr_d;
      sdata_q    <= sdata_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      err_pend_q <= err_pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_stall  = stall;
  assign bus.o_svalid = svalid_q;
  assign bus.o_saddr  = saddr_q;
  assign bus.o_sdata  = sdata_q;
  assign bus.o_ack    = ack_q;
  assign bus.o_err    = err_q;
endmodule
